// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between UART receiver/transmitter and the operand interface.
// Optional sticky overflow/underflow flags: define UART_FIFO_ERR_EN.
module uart_rx_fifo #(
  parameter int BUS_SIZE   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [BUS_SIZE-1:0]   w_data,
  input  logic                  rd,
  output logic [BUS_SIZE-1:0]   r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
`ifdef UART_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [BUS_SIZE-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign push = wr && (!full || rd);
  assign pop  = rd && !empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (push) w_ptr_d = w_ptr_q + 1'b1;
    if (pop)  r_ptr_d = r_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[w_ptr_q] <= w_data;
  end

  assign r_data = empty ? '0 : mem[r_ptr_q];

`ifdef UART_FIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr && full && !rd) ovf_q <= 1'b1;
      if (rd && empty)       unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Synchronous first-word-fall-through FIFO between the UART receiver and the operand-sequencing interface.
- Absorbs each received byte on the receiver's done tick and holds it until the interface pops it with its read strobe.
- Exports `empty`/`full` status so the interface can sequence operand A, operand B and the opcode without losing bytes.
- Also instantiated on the transmit side, between the interface result and the UART transmitter.

## Interface
- `BUS_SIZE`, default 8: data width in bits.
- `ADDR_WIDTH`, default 4: address bits; depth = 2^ADDR_WIDTH = 16 entries.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wr` input 1: push strobe; one push per cycle while high.
- `w_data` input BUS_SIZE: data pushed when `wr` is high.
- `rd` input 1: pop strobe; one pop per cycle while high.
- `r_data` output BUS_SIZE: head entry (first-word-fall-through).
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds 2^ADDR_WIDTH entries.
- `count` output ADDR_WIDTH+1: number of stored entries, 0..2^ADDR_WIDTH.
- `overflow` output 1: only with `UART_FIFO_ERR_EN`; sticky push-while-full flag.
- `underflow` output 1: only with `UART_FIFO_ERR_EN`; sticky pop-while-empty flag.

## Operation
- Storage: 2^ADDR_WIDTH x BUS_SIZE register array, not reset.
- Pointers: `w_ptr` and `r_ptr`, ADDR_WIDTH bits each, wrapping modulo 2^ADDR_WIDTH. `count` is a registered occupancy counter.
- Push is accepted when `wr && !full`:
  - writes `w_data` to `mem[w_ptr]`;
  - increments `w_ptr`.
- Pop is accepted when `rd && !empty`: increments `r_ptr`.
- Rejected operations leave all pointers, `count` and memory unchanged:
  - push while full;
  - pop while empty.
- Simultaneous `rd` and `wr`:
  - Neither full nor empty: both accepted; `count` unchanged.
  - Full: both accepted, because the pop frees the slot the push uses. `full` stays 1 and `count` stays 2^ADDR_WIDTH.
  - Empty: only the push is accepted; there is no bypass. `empty` falls next cycle.
- `count` next value:
  - +1 on push-only;
  - -1 on pop-only;
  - unchanged otherwise.
- `empty` is `count == 0` and `full` is `count == 2^ADDR_WIDTH`. Both are derived from the registered `count`.
- `r_data` = `empty ? 0 : mem[r_ptr]`. It is combinational from registered state, so it is glitch-free at the next edge.

## Timing
- Reset assertion (`reset` low) clears state immediately, independent of `clk`:
  - `w_ptr` = 0, `r_ptr` = 0, `count` = 0;
  - `empty` = 1, `full` = 0, `r_data` = 0;
  - `overflow` = 0 and `underflow` = 0 when compiled in.
- Reset asserted mid-operation discards all stored entries; memory contents become don't-care.
- First push or pop is sampled on the first rising edge after `reset` returns high.
- Write-to-read latency is 1 cycle. After a push into an empty FIFO at edge N:
  - `empty` = 0 after edge N;
  - `r_data` shows the pushed byte in the same cycle.
- Pop takes effect at the edge. After it, `r_data` shows the next entry, or 0 if the FIFO is now empty.
- `rd` held high for k cycles pops min(k, count) entries. The sequencing interface holds `rd` as a level, so this is relied upon.
- `full`, `empty` and `count` update on the same edge as the accepted operation.
- Pointer wrap from 2^ADDR_WIDTH-1 to 0 causes no bubble or data loss.

## Configuration
- Macro: `UART_FIFO_ERR_EN`.
- Defined:
  - `overflow` sets on any cycle with `wr && full && !rd`;
  - `underflow` sets on any cycle with `rd && empty`;
  - both are sticky until `reset` and do not affect data-path behaviour.
- Undefined: both ports and their registers are absent. Data-path behaviour is identical.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then hold `rd` for 3 cycles:
  - `r_data` reads 0x11, 0x22, 0x33 in turn;
  - `empty` = 1 afterwards;
  - `count` steps 3 → 0.
- Push 16 bytes 0x00..0x0F:
  - `full` = 1 and `count` = 16.
- From full, push 0xAA:
  - push is rejected;
  - popping 16 entries yields 0x00..0x0F;
  - `overflow` = 1 when the macro is defined.
- Fill to 16, then assert `rd` and `wr` with 0x55 together for 1 cycle:
  - `full` stays 1 and `count` = 16;
  - after 15 pops, `r_data` = 0x55.
- On empty, assert `rd` and `wr` with 0x77 together:
  - next cycle `count` = 1 and `r_data` = 0x77;
  - `underflow` = 1 when the macro is defined.
- Push 40 bytes and interleave pops so the pointers wrap twice: the output order matches the input order exactly.
- Assert `reset` low mid-stream with `count` = 5:
  - `empty` = 1, `count` = 0 and `r_data` = 0 before the next `clk` edge.
